// File: rtl/online_div_seq_ctrl_if.sv
// Control/handshake bundle between the online-division sequencer and the
// d/q digit-storage datapath plus its upstream digit source.
//
// Digit handshake: a digit transfers on a cycle where digit_valid and
// digit_ready are both 1. The controller raises digit_ready only in its
// WRITE state, and the source holds the d/q pair stable while digit_valid
// is 1 and digit_ready is 0. digit_valid carries no meaning outside WRITE.
interface online_div_seq_ctrl_if #(
   parameter int RAM_ADDR_WIDTH = 7,
   parameter int CNT_W          = RAM_ADDR_WIDTH + 2
);
   logic                      start;
   logic [CNT_W-1:0]          n_digits;
   logic                      digit_valid;
   logic                      digit_ready;
   logic [CNT_W-1:0]          master_cnt;
   logic [RAM_ADDR_WIDTH-1:0] rd_addr;
   logic [RAM_ADDR_WIDTH-1:0] comp_cycle;
   logic                      enable_all;
   logic                      wr_enable;
   logic                      busy;
   logic                      done;
   logic [2:0]                fsm_state;

   // controller side
   modport master (
      input  start, n_digits, digit_valid,
      output digit_ready, master_cnt, rd_addr, comp_cycle,
             enable_all, wr_enable, busy, done, fsm_state
   );

   // datapath / digit source side
   modport slave (
      output start, n_digits, digit_valid,
      input  digit_ready, master_cnt, rd_addr, comp_cycle,
             enable_all, wr_enable, busy, done, fsm_state
   );
endinterface

// File: rtl/online_div_seq_ctrl.sv
// Sequencer for the online-division digit store. For each digit j it sweeps
// word addresses 0..(j>>2) for the residual update, then waits in WRITE for
// one d/q digit pair and commits it. Because q lags d by one digit, a run
// ends with a single FLUSH write at index n before the done pulse.
// fsm_state exposes the state: 0 IDLE, 1 SWEEP, 2 WRITE, 3 FLUSH, 4 DONE.
module online_div_seq_ctrl #(
   parameter int RAM_ADDR_WIDTH = 7,
   parameter int CNT_W          = RAM_ADDR_WIDTH + 2
) (
   input logic                  clk,
   input logic                  async_clear,
   online_div_seq_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SWEEP = 3'd1,
      WRITE = 3'd2,
      FLUSH = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t                    state;
   state_t                    state_nxt;
   logic [CNT_W-1:0]          master_cnt;
   logic [CNT_W-1:0]          n_reg;
   logic [CNT_W-1:0]          cnt_inc;
   logic [RAM_ADDR_WIDTH-1:0] rd_addr;
   logic [RAM_ADDR_WIDTH-1:0] comp_cycle;
   logic                      handshake;
   logic                      last_digit;
   logic                      sweep_end;

   assign cnt_inc    = master_cnt + CNT_W'(1);
   assign handshake  = (state == WRITE) && bus.digit_valid;
   assign last_digit = (master_cnt == (n_reg - CNT_W'(1)));
   assign sweep_end  = (rd_addr == comp_cycle);

   // state register
   always_ff @(posedge clk or posedge async_clear) begin
      if (async_clear) state <= IDLE;
      else             state <= state_nxt;
   end

   // next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = (bus.n_digits == '0) ? DONE : SWEEP;
         SWEEP:   if (sweep_end) state_nxt = WRITE;
         WRITE:   if (handshake) state_nxt = last_digit ? FLUSH : SWEEP;
         FLUSH:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // digit index, sweep address and last-word index; all hold outside a run
   always_ff @(posedge clk or posedge async_clear) begin
      if (async_clear) begin
         n_reg      <= '0;
         master_cnt <= '0;
         rd_addr    <= '0;
         comp_cycle <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  n_reg      <= bus.n_digits;
                  master_cnt <= '0;
                  rd_addr    <= '0;
                  comp_cycle <= '0;
               end
            end
            SWEEP: begin
               if (!sweep_end) rd_addr <= rd_addr + RAM_ADDR_WIDTH'(1);
            end
            WRITE: begin
               if (handshake) begin
                  if (last_digit) begin
                     // flush index n_reg; rd_addr keeps the last swept word
                     master_cnt <= n_reg;
                     comp_cycle <= n_reg[CNT_W-1:2];
                  end else begin
                     master_cnt <= cnt_inc;
                     comp_cycle <= cnt_inc[CNT_W-1:2];
                     rd_addr    <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Moore outputs; wr_enable alone also looks at digit_valid
   always_comb begin
      bus.digit_ready = (state == WRITE);
      bus.wr_enable   = handshake || (state == FLUSH);
      bus.busy        = (state == SWEEP) || (state == WRITE) || (state == FLUSH);
      bus.enable_all  = (state == SWEEP) || (state == WRITE) || (state == FLUSH);
      bus.done        = (state == DONE);
      bus.master_cnt  = master_cnt;
      bus.rd_addr     = rd_addr;
      bus.comp_cycle  = comp_cycle;
      bus.fsm_state   = state;
   end

endmodule

// File: tb/tb_online_div_seq_ctrl.sv
// Bench for online_div_seq_ctrl: each run is expanded into a cycle-by-cycle
// list of expected outputs from the digit/word rules, then driven and
// compared in lockstep.
module tb_online_div_seq_ctrl;

   localparam int RAW = 7;
   localparam int CW  = RAW + 2;

   typedef struct {
      bit            ready;
      bit            wr;
      bit            busy;
      bit            done;
      logic [CW-1:0]  mc;
      logic [RAW-1:0] rd;
      logic [RAW-1:0] cc;
      bit            valid;
      int            dig;
      bit            sw0;
   } exp_t;

   logic clk = 1'b0;
   logic async_clear;
   int   checks = 0;
   int   errors = 0;
   int   wr_cnt;
   exp_t exp_q[$];

   online_div_seq_ctrl_if #(.RAM_ADDR_WIDTH(RAW), .CNT_W(CW)) bus ();

   online_div_seq_ctrl #(.RAM_ADDR_WIDTH(RAW), .CNT_W(CW)) dut (
      .clk         (clk),
      .async_clear (async_clear),
      .bus         (bus.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic exp_t mk(bit ready, bit wr, bit busy, bit done, int mc, int rd,
                               int cc, bit valid, int dig, bit sw0);
      exp_t e;
      e.ready = ready; e.wr = wr; e.busy = busy; e.done = done;
      e.mc = CW'(mc); e.rd = RAW'(rd); e.cc = RAW'(cc);
      e.valid = valid; e.dig = dig; e.sw0 = sw0;
      return e;
   endfunction

   // expected trace: per digit j, (j>>2)+1 sweep cycles, stalls, one write;
   // then flush, done, and one idle cycle
   task automatic build(input int n, input int stall_max, input int stall0);
      int s;
      exp_q.delete();
      if (n == 0) begin
         exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1'($urandom_range(0, 1)), -1, 0));
         exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)), -1, 0));
      end else begin
         for (int j = 0; j < n; j++) begin
            for (int a = 0; a <= (j / 4); a++)
               exp_q.push_back(mk(0, 0, 1, 0, j, a, j / 4, 1'($urandom_range(0, 1)), j, a == 0));
            s = (j == 0 && stall0 >= 0) ? stall0 : int'($urandom_range(0, stall_max));
            repeat (s) exp_q.push_back(mk(1, 0, 1, 0, j, j / 4, j / 4, 0, j, 0));
            exp_q.push_back(mk(1, 1, 1, 0, j, j / 4, j / 4, 1, j, 0));
         end
         exp_q.push_back(mk(0, 1, 1, 0, n, (n - 1) / 4, n / 4, 1'($urandom_range(0, 1)), n, 0));
         exp_q.push_back(mk(0, 0, 0, 1, n, (n - 1) / 4, n / 4, 1'($urandom_range(0, 1)), n, 0));
         exp_q.push_back(mk(0, 0, 0, 0, n, (n - 1) / 4, n / 4, 1'($urandom_range(0, 1)), n, 0));
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, 32'(bus.digit_ready), 0);
      chk({tag, "_wr"},    32'(bus.wr_enable), 0);
      chk({tag, "_busy"},  32'(bus.busy), 0);
      chk({tag, "_en"},    32'(bus.enable_all), 0);
      chk({tag, "_done"},  32'(bus.done), 0);
      chk({tag, "_mc"},    32'(bus.master_cnt), 0);
      chk({tag, "_rd"},    32'(bus.rd_addr), 0);
      chk({tag, "_cc"},    32'(bus.comp_cycle), 0);
      chk({tag, "_state"}, 32'(bus.fsm_state), 0);
   endtask

   task automatic run(input int n, input int stall_max, input int stall0, input bit poke,
                      input int abort_digit);
      exp_t e;
      build(n, stall_max, stall0);
      wr_cnt = 0;
      @(posedge clk); #1;
      bus.start    = 1'b1;
      bus.n_digits = CW'(n);
      @(posedge clk); #1;
      bus.start = 1'b0;
      foreach (exp_q[i]) begin
         e = exp_q[i];
         if (i > 0) begin
            @(posedge clk); #1;
         end
         bus.digit_valid = e.valid;
         if (poke && (e.busy || e.done)) begin
            bus.start    = 1'($urandom_range(0, 1));
            bus.n_digits = CW'($urandom_range(0, 40));
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
         chk("ready", 32'(bus.digit_ready), 32'(e.ready));
         chk("wr",    32'(bus.wr_enable),   32'(e.wr));
         chk("busy",  32'(bus.busy),        32'(e.busy));
         chk("en",    32'(bus.enable_all),  32'(e.busy));
         chk("done",  32'(bus.done),        32'(e.done));
         chk("mc",    32'(bus.master_cnt),  32'(e.mc));
         chk("rd",    32'(bus.rd_addr),     32'(e.rd));
         chk("cc",    32'(bus.comp_cycle),  32'(e.cc));
         if (bus.wr_enable === 1'b1) wr_cnt++;
         if (abort_digit >= 0 && e.dig == abort_digit && e.sw0) begin
            #2 async_clear = 1'b1;
            #1 chk_all_zero("abort");
            repeat (3) begin
               @(negedge clk);
               chk("abort_done", 32'(bus.done), 0);
               chk("abort_wr",   32'(bus.wr_enable), 0);
            end
            #1 async_clear = 1'b0;
            break;
         end
      end
      bus.start       = 1'b0;
      bus.digit_valid = 1'b0;
   endtask

   initial begin
      async_clear     = 1'b1;
      bus.start       = 1'b0;
      bus.n_digits    = '0;
      bus.digit_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      async_clear = 1'b0;

      // single digit: sweep, write, flush, done
      run(1, 0, -1, 0, -1);
      chk("n1_writes", 32'(wr_cnt), 32'd2);

      // five digits: digit 4 sweeps two words
      run(5, 0, -1, 0, -1);
      chk("n5_writes", 32'(wr_cnt), 32'd6);

      // three-cycle stall on the first write
      run(2, 0, 3, 0, -1);
      chk("stall_writes", 32'(wr_cnt), 32'd3);

      // empty run goes straight to done
      run(0, 0, -1, 0, -1);
      chk("n0_writes", 32'(wr_cnt), 32'd0);

      // reset mid-sweep of digit 6, then a clean run
      run(10, 0, -1, 0, 6);
      run(1, 0, -1, 0, -1);
      chk("post_abort_writes", 32'(wr_cnt), 32'd2);

      // start pulses while busy are ignored
      run(3, 1, -1, 1, -1);
      chk("poke_writes", 32'(wr_cnt), 32'd4);

      // randomized lengths, stalls and stray starts
      repeat (6) begin
         int n;
         n = int'($urandom_range(1, 24));
         run(n, 3, -1, 1, -1);
         chk("rand_writes", 32'(wr_cnt), 32'(n + 1));
      end

      // largest run: flush index is the top counter value
      run((1 << CW) - 1, 0, -1, 0, -1);
      chk("max_writes", 32'(wr_cnt), 32'(1 << CW));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
